// File: rtl/inpkt_parser.sv
// inpkt_parser: strips header/trailer from a byte stream,
// forwards the payload and verifies header and trailer checksums.
module inpkt_parser #(
  parameter logic [7:0]  PKT_VERSION = 8'd2,
  parameter logic [23:0] MAX_LEN     = 24'd65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        empty,
  output logic        rd_en,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic [23:0] pkt_len,
  output logic        pkt_done,
  output logic        err,
  output logic [2:0]  err_code
);

  typedef enum logic [1:0] {
    HDR, PAYLOAD, TRAILER, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  ver_q, ver_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] id_q, id_d;
  logic [23:0] len_q, len_d;
  logic [7:0]  hx_q, hx_d;
  logic [23:0] wbuf_q, wbuf_d;
  logic [31:0] sum_q, sum_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic        rd, vld;
  logic [2:0]  hcode;
  logic        is_last;

  assign is_last = (cnt_q == len_q - 24'd1);

  // Header check priority, evaluated while the checksum byte is on din
  always_comb begin
    hcode = 3'd0;
    if (ver_q != PKT_VERSION)
      hcode = 3'd1;
    else if (type_q == 8'd0)
      hcode = 3'd2;
    else if (len_q == 24'd0 || len_q > MAX_LEN ||
             len_q[1:0] != 2'b00)
      hcode = 3'd3;
    else if (hx_q != din)
      hcode = 3'd4;
  end

  // Next-state, field capture, payload sum and handshake logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ver_d   = ver_q;
    type_d  = type_q;
    id_d    = id_q;
    len_d   = len_q;
    hx_d    = hx_q;
    wbuf_d  = wbuf_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    rd      = 1'b0;
    vld     = 1'b0;
    unique case (state_q)
      HDR: begin
        rd = ~empty;
        if (rd) begin
          cnt_d = cnt_q + 24'd1;
          hx_d  = hx_q ^ din;
          unique case (cnt_q[2:0])
            3'd0: begin
              ver_d = din;
              hx_d  = din;
            end
            3'd1: type_d = din;
            3'd2: len_d[7:0] = din;
            3'd3: len_d[15:8] = din;
            3'd4: len_d[23:16] = din;
            3'd5: id_d[7:0] = din;
            3'd6: id_d[15:8] = din;
            3'd7: begin
              cnt_d = 24'd0;
              if (hcode != 3'd0) begin
                state_d = ERROR;
                err_d   = 1'b1;
                code_d  = hcode;
              end else begin
                state_d = PAYLOAD;
              end
            end
          endcase
        end
      end
      PAYLOAD: begin
        vld = ~empty;
        rd  = ~empty & dout_ready;
        if (rd) begin
          unique case (cnt_q[1:0])
            2'd0: wbuf_d[7:0] = din;
            2'd1: wbuf_d[15:8] = din;
            2'd2: wbuf_d[23:16] = din;
            2'd3: sum_d = sum_q + {din, wbuf_q};
          endcase
          if (is_last) begin
            state_d = TRAILER;
            cnt_d   = 24'd0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
      end
      TRAILER: begin
        rd = ~empty;
        if (rd) begin
          cnt_d = cnt_q + 24'd1;
          unique case (cnt_q[1:0])
            2'd0: wbuf_d[7:0] = din;
            2'd1: wbuf_d[15:8] = din;
            2'd2: wbuf_d[23:16] = din;
            2'd3: begin
              cnt_d = 24'd0;
              if ({din, wbuf_q} == sum_q) begin
                state_d = HDR;
                done_d  = 1'b1;
                sum_d   = 32'd0;
              end else begin
                state_d = ERROR;
                err_d   = 1'b1;
                code_d  = 3'd5;
              end
            end
          endcase
        end
      end
      ERROR: begin
        rd  = 1'b0;
        vld = 1'b0;
      end
      default: state_d = ERROR;
    endcase
  end

  // State and datapath registers, all cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
      cnt_q   <= '0;
      ver_q   <= '0;
      type_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      hx_q    <= '0;
      wbuf_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ver_q   <= ver_d;
      type_q  <= type_d;
      id_q    <= id_d;
      len_q   <= len_d;
      hx_q    <= hx_d;
      wbuf_q  <= wbuf_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign rd_en      = rst_n & rd;
  assign dout_valid = rst_n & vld;
  assign dout       = din;
  assign dout_last  = dout_valid & is_last;
  assign pkt_type   = type_q;
  assign pkt_id     = id_q;
  assign pkt_len    = len_q;
  assign pkt_done   = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_inpkt_parser.sv
// tb_inpkt_parser: random/directed packet streams checked
// against a byte-level packet model.
module tb_inpkt_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        empty = 1'b1;
  logic        rd_en;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_last;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic [23:0] pkt_len;
  logic        pkt_done;
  logic        err;
  logic [2:0]  err_code;

  inpkt_parser dut (
    .clk(clk), .rst_n(rst_n), .din(din), .empty(empty),
    .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last),
    .pkt_type(pkt_type), .pkt_id(pkt_id), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] fifo_q[$];
  logic [7:0] exp_pay_q[$];
  logic [7:0] got_q[$];
  bit         exp_last_q[$];
  bit         got_last_q[$];
  int         exp_done, exp_pops, exp_code;
  logic [7:0]  exp_type;
  logic [15:0] exp_id;
  logic [23:0] exp_len;
  int pops, first_c, last_c, viol, done_seen;
  bit timed_out;

  task automatic clear_exp();
    fifo_q.delete();
    exp_pay_q.delete();
    exp_last_q.delete();
    exp_done = 0;
    exp_pops = 0;
    exp_code = 0;
  endtask

  // Appends one packet to the FIFO and predicts its outcome
  task automatic add_pkt(input logic [7:0] ver,
                         input logic [7:0] typ,
                         input logic [23:0] len,
                         input logic [15:0] id,
                         input logic [7:0] hx_delta,
                         input logic [31:0] tr_delta,
                         input bit fixed);
    logic [7:0]  h[8];
    logic [7:0]  p[$];
    logic [7:0]  x;
    logic [31:0] s, tr;
    int code;
    h[0] = ver; h[1] = typ;
    h[2] = len[7:0]; h[3] = len[15:8]; h[4] = len[23:16];
    h[5] = id[7:0]; h[6] = id[15:8];
    x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ h[i];
    h[7] = x ^ hx_delta;
    code = 0;
    if (ver != 8'd2) code = 1;
    else if (typ == 8'd0) code = 2;
    else if (len == 0 || len > 65536 || len % 4 != 0) code = 3;
    else if (h[7] != x) code = 4;
    for (int i = 0; i < 8; i++) fifo_q.push_back(h[i]);
    if (code != 0) begin
      for (int i = 0; i < 4; i++)
        fifo_q.push_back(8'($urandom));
      exp_pops += 8;
      exp_code = code;
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      logic [7:0] b;
      b = fixed ? 8'(i + 1) : 8'($urandom);
      p.push_back(b);
      fifo_q.push_back(b);
      exp_pay_q.push_back(b);
      exp_last_q.push_back(i == int'(len) - 1);
    end
    s = 32'd0;
    for (int w = 0; w < int'(len) / 4; w++)
      s = s + {p[4*w+3], p[4*w+2], p[4*w+1], p[4*w]};
    tr = s + tr_delta;
    for (int i = 0; i < 4; i++) fifo_q.push_back(tr[8*i +: 8]);
    exp_pops += 8 + int'(len) + 4;
    if (tr_delta != 0) begin
      exp_code = 5;
    end else begin
      exp_done++;
      exp_type = typ;
      exp_id = id;
      exp_len = len;
    end
  endtask

  task automatic set_inputs(input bit gaps);
    empty = (fifo_q.size() == 0) ||
            (gaps && $urandom_range(0, 3) == 0);
    din = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    dout_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    fifo_q.delete();
    empty = 1'b0;
    din = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    set_inputs(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic run(input bit gaps, input int abort_after);
    int cyc, tail;
    bit pop;
    cyc = 0; tail = 0;
    pops = 0; first_c = -1; last_c = -1;
    viol = 0; done_seen = 0; timed_out = 1'b0;
    got_q.delete();
    got_last_q.delete();
    set_inputs(gaps);
    while (cyc < 4000) begin
      @(negedge clk);
      pop = rd_en;
      if (rd_en && empty) viol++;
      if (dout_valid && dout_ready) begin
        got_q.push_back(dout);
        got_last_q.push_back(dout_last);
      end
      if (pkt_done) done_seen++;
      if (rd_en) begin
        pops++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      cyc++;
      set_inputs(gaps);
      if (abort_after >= 0 && got_q.size() == abort_after)
        return;
      if (fifo_q.size() == 0 || err) tail++;
      else tail = 0;
      if (tail > 4) break;
    end
    timed_out = (cyc >= 4000);
  endtask

  task automatic verify(input bit gaps, input string nm);
    int mp, ml, n;
    chk({nm, ".timeout"}, 32'(timed_out), 32'd0);
    chk({nm, ".npay"}, got_q.size(), exp_pay_q.size());
    n = got_q.size() < exp_pay_q.size() ?
        got_q.size() : exp_pay_q.size();
    mp = 0; ml = 0;
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_pay_q[i]) mp++;
      if (got_last_q[i] != exp_last_q[i]) ml++;
    end
    chk({nm, ".paydata"}, mp, 0);
    chk({nm, ".last"}, ml, 0);
    chk({nm, ".done"}, done_seen, exp_done);
    chk({nm, ".err"}, 32'(err), 32'(exp_code != 0));
    chk({nm, ".code"}, 32'(err_code), exp_code);
    chk({nm, ".pops"}, pops, exp_pops);
    chk({nm, ".rd_empty"}, viol, 0);
    if (!gaps)
      chk({nm, ".contig"}, last_c - first_c + 1, pops);
    if (exp_code == 0 && exp_done > 0) begin
      chk({nm, ".type"}, 32'(pkt_type), 32'(exp_type));
      chk({nm, ".id"}, 32'(pkt_id), 32'(exp_id));
      chk({nm, ".len"}, 32'(pkt_len), 32'(exp_len));
    end
  endtask

  initial begin
    clear_exp();
    empty = 1'b0;
    din = 8'hAA;
    repeat (2) @(negedge clk);
    chk("rst.rd_en", 32'(rd_en), 0);
    chk("rst.dout_valid", 32'(dout_valid), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.code", 32'(err_code), 0);
    chk("rst.done", 32'(pkt_done), 0);
    chk("rst.len", 32'(pkt_len), 0);
    chk("rst.id", 32'(pkt_id), 0);
    chk("rst.type", 32'(pkt_type), 0);
    @(posedge clk);
    #1;
    empty = 1'b1;
    rst_n = 1'b1;

    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd8, 16'h1234, 8'd0, 32'd0, 1'b1);
    chk("good.trailer",
        {fifo_q[19], fifo_q[18], fifo_q[17], fifo_q[16]},
        32'h0C0A0806);
    run(1'b0, -1);
    verify(1'b0, "good");

    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd8, 16'h1234, 8'd0, 32'd0, 1'b1);
    run(1'b1, -1);
    verify(1'b1, "gaps");

    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd8, 16'h1234, 8'd0, 32'd0, 1'b1);
    add_pkt(8'd2, 8'd7, 24'd16, 16'hBEEF, 8'd0, 32'd0, 1'b0);
    run(1'b0, -1);
    verify(1'b0, "b2b");

    clear_exp();
    add_pkt(8'd3, 8'd1, 24'd8, 16'h1234, 8'd0, 32'd0, 1'b1);
    run(1'b0, -1);
    verify(1'b0, "ver");
    chk("ver.left", fifo_q.size(), 4);
    do_reset();
    chk("ver.clr", 32'(err), 0);
    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd8, 16'h1234, 8'd0, 32'd0, 1'b1);
    run(1'b0, -1);
    verify(1'b0, "recover");

    do_reset();
    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd6, 16'h0001, 8'd0, 32'd0, 1'b1);
    run(1'b0, -1);
    verify(1'b0, "len6");

    do_reset();
    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd65540, 16'h0002, 8'd0, 32'd0, 1'b1);
    run(1'b0, -1);
    verify(1'b0, "lenmax");

    do_reset();
    clear_exp();
    add_pkt(8'd2, 8'd0, 24'd8, 16'h0003, 8'd0, 32'd0, 1'b1);
    run(1'b0, -1);
    verify(1'b0, "type0");

    do_reset();
    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd8, 16'h0004, 8'h40, 32'd0, 1'b1);
    run(1'b0, -1);
    verify(1'b0, "hcsum");

    do_reset();
    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd8, 16'h0005, 8'd0, 32'd1, 1'b1);
    run(1'b0, -1);
    verify(1'b0, "trailer");

    do_reset();
    clear_exp();
    add_pkt(8'd2, 8'd1, 24'd8, 16'h1234, 8'd0, 32'd0, 1'b1);
    run(1'b0, 2);
    chk("midrst.pre", 32'(dout_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.rd_en", 32'(rd_en), 0);
    chk("midrst.valid", 32'(dout_valid), 0);
    chk("midrst.len", 32'(pkt_len), 0);
    chk("midrst.id", 32'(pkt_id), 0);
    chk("midrst.type", 32'(pkt_type), 0);
    do_reset();
    clear_exp();
    add_pkt(8'd2, 8'd9, 24'd12, 16'h5A5A, 8'd0, 32'd0, 1'b0);
    run(1'b0, -1);
    verify(1'b0, "midrst.after");

    for (int it = 0; it < 20; it++) begin
      int np, kind;
      do_reset();
      clear_exp();
      np = $urandom_range(1, 3);
      for (int k = 0; k < np; k++) begin
        logic [7:0]  v, t, hd;
        logic [23:0] l;
        logic [31:0] td;
        kind = (k == np - 1) ? $urandom_range(0, 5) : 0;
        v = (kind == 1) ? 8'(2 + $urandom_range(1, 200)) : 8'd2;
        t = (kind == 2) ? 8'd0 : 8'($urandom_range(1, 255));
        l = 24'(4 * $urandom_range(1, 8));
        if (kind == 3) begin
          unique case ($urandom_range(0, 2))
            0: l = 24'd0;
            1: l = 24'd65540;
            default: l = 24'(4 * $urandom_range(1, 8) + 2);
          endcase
        end
        hd = (kind == 4) ? 8'($urandom_range(1, 255)) : 8'd0;
        td = (kind == 5) ? 32'($urandom_range(1, 1000)) : 32'd0;
        add_pkt(v, t, l, 16'($urandom), hd, td, 1'b0);
      end
      run(1'b1, -1);
      verify(1'b1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inpkt_parser.md
INPKT_PARSER -- requirements
Module: inpkt_parser

Interface
REQ-001 SHALL have parameter PKT_VERSION, default 2, meaning the only accepted header version byte.
REQ-002 SHALL have parameter MAX_LEN, default 24'd65536, meaning the maximum payload length in bytes.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port din  input  8  byte from the upstream first-word-fall-through FIFO.
REQ-006 SHALL have port empty  input  1  upstream FIFO empty; din is valid when low.
REQ-007 SHALL have port rd_en  output  1  pops the upstream FIFO.
REQ-008 SHALL have port dout  output  8  payload byte.
REQ-009 SHALL have port dout_valid  output  1  dout is valid.
REQ-010 SHALL have port dout_ready  input  1  downstream accepts dout.
REQ-011 SHALL have port dout_last  output  1  dout is the last payload byte.
REQ-012 SHALL have ports pkt_type (output, 8 bits), pkt_id (output, 16 bits) and pkt_len (output, 24 bits), holding the header fields of the current packet.
REQ-013 SHALL have port pkt_done  output  1  one-cycle pulse when a packet passes its trailer check.
REQ-014 SHALL have port err  output  1  sticky error flag.
REQ-015 SHALL have port err_code  output  3  cause of the first error.

Function
REQ-016 SHALL accept packets in this format: 8-byte header, then pkt_len payload bytes, then a 4-byte trailer.
- Header bytes, in order: version, type, len[7:0], len[15:8], len[23:16], id[7:0], id[15:8], hcsum.
- hcsum is the XOR of header bytes 0-6.
- Trailer: 32-bit little-endian value equal to the modulo-2^32 sum of the payload taken as little-endian 32-bit words.
REQ-017 SHALL implement states HDR, PAYLOAD, TRAILER and ERROR.
REQ-018 In HDR and TRAILER, rd_en SHALL equal ~empty, with one byte consumed per cycle that rd_en is high.
REQ-019 In PAYLOAD, rd_en, dout_valid and dout SHALL behave as a combinational pass-through with zero latency:
- dout_valid = ~empty.
- dout = din.
- rd_en = ~empty & dout_ready.
REQ-020 In ERROR, rd_en and dout_valid SHALL be 0.
REQ-021 A byte counter SHALL count consumed bytes within each state and clear on every state transition.
REQ-022 On the 8th header byte, the block SHALL perform these checks in this priority order:
- version != PKT_VERSION -> err_code 1.
- type == 0 -> err_code 2.
- len == 0, len > MAX_LEN, or len[1:0] != 0 -> err_code 3.
- hcsum mismatch -> err_code 4.
- Any failure -> ERROR; otherwise -> PAYLOAD.
REQ-023 pkt_type, pkt_id and pkt_len SHALL be registered as bytes arrive and SHALL be stable from PAYLOAD entry until the next packet's first header byte is consumed.
REQ-024 dout_last SHALL be high when dout_valid is high and the payload counter equals pkt_len-1.
REQ-025 Acceptance of the last payload byte SHALL transition to TRAILER.
REQ-026 The payload sum SHALL assemble bytes into 32-bit words, little-endian, and add each word modulo 2^32 on acceptance of its 4th byte.
REQ-027 On the 4th trailer byte:
- On match, pkt_done SHALL pulse for one cycle, the sum SHALL clear, and the state SHALL return to HDR.
- On mismatch, err_code SHALL be 5 and the state SHALL go to ERROR.
REQ-028 ERROR SHALL be exited only by reset.
REQ-029 err SHALL rise in the cycle after the failing byte is consumed, and err_code SHALL hold the first cause.
REQ-030 When empty or dout_ready is low mid-packet, the counters and sum SHALL hold, with no timeout.
REQ-031 Back-to-back packets SHALL incur no idle cycle: the next header byte may be consumed in the cycle after the 4th trailer byte.

Reset
REQ-032 Assertion of rst_n low SHALL immediately, at any state including mid-payload, force the following, with all partial packet state discarded:
- state HDR.
- Counters, sum, pkt_type, pkt_id and pkt_len 0.
- pkt_done, err and err_code 0.
- dout_valid and rd_en 0 while rst_n is low.
REQ-033 After rst_n deasserts, the block SHALL treat the next byte consumed as header byte 0.

Verification
REQ-034 Good packet, streamed continuously with dout_ready=1 throughout:
- Stimulus: version=2, type=1, len=8, id=0x1234, payload 01..08, trailer 0x0C0A0806.
- Required response: 8 dout bytes 01..08, dout_last on 08, pkt_id=0x1234, pkt_done pulse, err=0.
REQ-035 Same packet with random empty gaps and random dout_ready low:
- Required response: identical dout byte sequence and pkt_done; no byte dropped or duplicated.
REQ-036 Version byte 3:
- Required response: err=1, err_code=1, rd_en stays 0 afterwards; pulsing rst_n clears err and the next good packet passes.
REQ-037 len=6, and separately len=MAX_LEN+4:
- Required response: err_code=3 in both cases.
REQ-038 Header checksum altered:
- Required response: err_code=4.
REQ-039 Trailer off by one:
- Required response: err_code=5, no pkt_done.
REQ-040 Two good packets back-to-back:
- Required response: two pkt_done pulses and no idle rd_en cycle between them.
REQ-041 rst_n asserted during payload byte 3:
- Required response: outputs reset immediately; a new good packet afterwards passes.
